spike_event_encoder: RTL

Downstream stage of the integrate-and-fire neuron. Consumes the neuron's 1-bit spike output and stamps each spike with a free-running timestamp. Events are buffered in a small FIFO and drained over a valid/ready interface. The block also reports a per-window spike rate for the readout logic.

---
 rtl/spike_event_encoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spike_event_encoder.sv
// Timestamps spikes from the IF neuron, queues them in a small FIFO drained over
// valid/ready, and reports a saturating per-window spike rate.
module spike_event_encoder #(
   parameter int unsigned TS_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WINDOW     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                spike,
   output logic [TS_WIDTH-1:0] evt_data,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic                overflow,
   input  logic                clr_overflow,
   output logic [7:0]          rate,
   output logic                rate_valid
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WC_W  = $clog2(WINDOW);
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fstate_t;

   fstate_t             r_fstate;
   fstate_t             w_fstate_nxt;
   logic [TS_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [TS_WIDTH-1:0] r_ts;
   logic [TS_WIDTH-1:0] r_evt_data;
   logic [TS_WIDTH-1:0] w_head_nxt;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [PTR_W-1:0]    w_rptr_nxt;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [WC_W-1:0]     r_wcnt;
   logic [7:0]          r_scnt;
   logic [7:0]          w_scnt_inc;
   logic [7:0]          r_rate;
   logic                r_evt_valid;
   logic                r_overflow;
   logic                r_rate_valid;
   logic                w_capture;
   logic                w_push;
   logic                w_pop;
   logic                w_drop;

   assign w_capture = en & spike;
   assign w_pop     = r_evt_valid & evt_ready;
   assign w_push    = w_capture & ((r_fstate != FULL) | w_pop);
   assign w_drop    = w_capture & ~w_push;
   assign w_cnt_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_rptr_nxt = r_rptr + PTR_W'(w_pop);
   assign w_scnt_inc = (w_capture && r_scnt != 8'hFF) ? r_scnt + 8'd1 : r_scnt;

   always_comb begin
      w_fstate_nxt = PARTIAL;
      if (w_cnt_nxt == '0)
         w_fstate_nxt = EMPTY;
      else if (w_cnt_nxt == CNT_FULL)
         w_fstate_nxt = FULL;
   end

   // When the surviving queue is empty the incoming event becomes the head and
   // has not reached the memory yet, so forward it directly.
   always_comb begin
      w_head_nxt = r_mem[w_rptr_nxt];
      if (w_push && w_rptr_nxt == r_wptr)
         w_head_nxt = r_ts;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= r_ts;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts         <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_fstate     <= EMPTY;
         r_evt_valid  <= 1'b0;
         r_evt_data   <= '0;
         r_overflow   <= 1'b0;
         r_wcnt       <= '0;
         r_scnt       <= '0;
         r_rate       <= '0;
         r_rate_valid <= 1'b0;
      end else begin
         if (en)
            r_ts <= r_ts + 1'b1;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         r_rptr      <= w_rptr_nxt;
         r_count     <= w_cnt_nxt;
         r_fstate    <= w_fstate_nxt;
         r_evt_valid <= (w_cnt_nxt != '0);
         if (w_cnt_nxt != '0)
            r_evt_data <= w_head_nxt;

         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_overflow)
            r_overflow <= 1'b0;

         r_rate_valid <= 1'b0;
         if (en) begin
            if (r_wcnt == WC_LAST) begin
               r_rate       <= w_scnt_inc;
               r_rate_valid <= 1'b1;
               r_wcnt       <= '0;
               r_scnt       <= '0;
            end else begin
               r_wcnt <= r_wcnt + 1'b1;
               r_scnt <= w_scnt_inc;
            end
         end
      end
   end

   assign evt_data   = r_evt_data;
   assign evt_valid  = r_evt_valid;
   assign overflow   = r_overflow;
   assign rate       = r_rate;
   assign rate_valid = r_rate_valid;

endmodule
